eth_byte_fcs: RTL and testbench
===============================

// Module: eth_byte_fcs
// PURPOSE
//  Downstream of the RMII receive stage. Consumes its post-SFD dibit stream
//  (axiiv/axiid) and reassembles it into bytes, LSB dibit first.
//  Checks the Ethernet CRC-32 FCS and reports length, runt and oversize status
//  once per frame. Output bytes include the 4 FCS bytes; stripping is done downstream.
// PARAMETERS
//  MIN_BYTES  64     frames with len < MIN_BYTES flag runt=1
//  MAX_BYTES  1522   byte count saturates here; beyond it, oversize=1
//  MY_MAC     48'h0  station address; used only with ETH_MAC_FILTER_EN
// PORTS
//  clk       in   1   50 MHz clock
//  rst       in   1   synchronous reset, active-high
//  axiiv     in   1   dibit valid; high for the whole frame body, low between frames
//  axiid     in   2   dibit, rxd order
//  axiov     out  1   byte valid, single-cycle pulse per byte
//  axiod     out  8   assembled byte
//  done      out  1   single-cycle end-of-frame pulse
//  fcs_ok    out  1   CRC residue correct and frame ended on a byte boundary
//  runt      out  1   len < MIN_BYTES
//  oversize  out  1   more than MAX_BYTES bytes received
//  addr_ok   out  1   destination matched (tied 1 without ETH_MAC_FILTER_EN)
//  len       out  11  byte count of the frame, FCS included
// BEHAVIOUR
//  - Reset: every output is 0, except addr_ok=1. FSM goes to IDLE; shift reg, dibit ctr, byte ctr and crc are cleared.
//  - FSM: IDLE --axiiv=1--> RECV; RECV --axiiv=0--> IDLE, and done pulses the next cycle.
//  - On the IDLE->RECV cycle: crc=32'hFFFFFFFF, dibit ctr=0, byte ctr=0, then the first dibit is absorbed.
//  - Assembly: sh <= {axiid, sh[7:2]}; dibit ctr 2-bit wraps 3->0.
//  - First dibit lands in bits [1:0] of the byte.
//  - Byte emit: on the cycle a 4th dibit is taken, the next cycle has axiov=1 and axiod=byte.
//  - Latency is 1 clk after the 4th dibit. Max rate is 1 byte per 4 clk.
//  - CRC: reflected poly 32'hEDB88320, 2 bits per accepted dibit, bit axiid[0] first.
//  - No final xor. Every dibit is folded in, FCS included.
//  - fcs_ok = (crc == 32'hDEBB20E3) && (dibit ctr == 0) && !oversize.
//  - A partial trailing byte is not emitted, and it forces fcs_ok=0.
//  - Byte ctr: 11 bits, saturating at MAX_BYTES. oversize is set once a byte
//    arrives with ctr == MAX_BYTES; that byte and later bytes are still emitted.
//  - done cycle: fcs_ok, runt, oversize, addr_ok and len are all valid.
//  - Those status outputs hold until the next IDLE->RECV, where they clear to
//    their reset values. done itself is 0 on all other cycles.
//  - Gap of 1 clk (axiiv 1,0,1): done pulses in the same cycle as the new frame's
//    first dibit. The new frame is captured normally.
//  - rst mid-frame: frame is dropped, no done pulse, no further axiov. Next frame decodes cleanly.
//  - A single-dibit frame (axiiv high 1 clk) gives done, len=0, fcs_ok=0, runt=1.
// CONFIGURATION
//  ETH_MAC_FILTER_EN defined:
//   - Bytes 0..5 are compared with MY_MAC[47:40]..MY_MAC[7:0], and also with broadcast FF:FF:FF:FF:FF:FF.
//   - addr_ok is decided as byte 5 is taken.
//   - On a mismatch, axiov is suppressed from byte 6 on. done still pulses, with addr_ok=0 and fcs_ok still computed.
//   - Frames ending before byte 6 report addr_ok=0.
//  ETH_MAC_FILTER_EN undefined: no compare logic, addr_ok=1 always, all bytes emitted.
// TESTING
//  1. "123456789" (31..39) + FCS 26 39 F4 CB, byte 0x31 sent as dibits 01,00,11,00
//     -> 13 axiov pulses matching the bytes; done with fcs_ok=1, runt=1, len=13.
//  2. 60 bytes 0x00..0x3B + correct FCS
//     -> len=64, fcs_ok=1, runt=0, oversize=0.
//     Then the same frame with byte 10 bit 0 flipped -> fcs_ok=0.
//  3. Frame 1 plus one extra dibit 2'b10 -> 13 bytes emitted, len=13, fcs_ok=0.
//  4. Case 2 back-to-back with a 1-clk axiiv gap
//     -> both frames report fcs_ok=1, len=64. done_1 coincides with frame 2's first dibit.
//  5. rst asserted after 20 bytes of a frame, then frame 2 sent
//     -> no done for the aborted frame; one done with fcs_ok=1.
//  6. MAX_BYTES=16 with frame 2 -> len=16, oversize=1, fcs_ok=0, 64 axiov pulses.
//     With ETH_MAC_FILTER_EN and MY_MAC=48'h02_00_00_00_00_01, DA 02:00:00:00:00:02
//     -> 6 axiov pulses, addr_ok=0.

Source files
------------

// File: rtl/eth_byte_fcs.sv
// ============================================================================
// eth_byte_fcs
// ----------------------------------------------------------------------------
// Sits behind the RMII receive stage. Takes the post-SFD dibit stream,
// reassembles it into bytes (LSB dibit first), runs the Ethernet CRC-32 over
// every dibit (FCS included) and reports per-frame status on a one-cycle
// done pulse. Emitted bytes include the four FCS bytes.
//
// Optional feature (compile-time macro ETH_MAC_FILTER_EN):
//   Destination address filter against MY_MAC and broadcast. On a mismatch,
//   byte output is suppressed from byte 6 on and addr_ok reports 0.
//   Without the macro, addr_ok is tied to 1 and every byte is emitted.
//
// Parameters
//   MIN_BYTES  frames shorter than this report runt
//   MAX_BYTES  byte count saturates here; any further byte sets oversize
//   MY_MAC     station address (filter build only)
//
// Ports
//   clk       in   1   clock
//   rst       in   1   synchronous reset, active-high
//   axiiv     in   1   dibit valid, high for the whole frame body
//   axiid     in   2   dibit
//   axiov     out  1   byte valid, one-cycle pulse per byte
//   axiod     out  8   assembled byte
//   done      out  1   one-cycle end-of-frame pulse
//   fcs_ok    out  1   CRC residue good, byte-aligned end, not oversize
//   runt      out  1   len < MIN_BYTES
//   oversize  out  1   more than MAX_BYTES bytes received
//   addr_ok   out  1   destination matched (always 1 without the filter)
//   len       out  11  byte count of the frame, FCS included (saturating)
// ============================================================================
module eth_byte_fcs #(
    parameter int          MIN_BYTES = 64,
    parameter int          MAX_BYTES = 1522,
    parameter logic [47:0] MY_MAC    = 48'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        axiiv,
    input  logic [1:0]  axiid,
    output logic        axiov,
    output logic [7:0]  axiod,
    output logic        done,
    output logic        fcs_ok,
    output logic        runt,
    output logic        oversize,
    output logic        addr_ok,
    output logic [10:0] len
);

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [10:0] MAX_LEN     = 11'(MAX_BYTES);
    localparam logic [10:0] MIN_LEN     = 11'(MIN_BYTES);

    // Reflected CRC-32, two bits per call, d[0] folded in first.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            r = {1'b0, r[31:1]} ^ ({32{r[0] ^ d[i]}} & CRC_POLY);
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t state_reg;
    state_t state_next;
    logic   frame_start;
    logic   frame_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (axiiv)  state_next = RECV;
            RECV:    if (!axiiv) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state_reg)
            IDLE:    frame_start = axiiv;
            RECV:    frame_end   = !axiiv;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Byte assembly and CRC
    // ------------------------------------------------------------------
    logic [7:0]  sh_reg;
    logic [1:0]  dibit_ctr_reg;
    logic [10:0] byte_ctr_reg;
    logic [31:0] crc_reg;
    logic        ovf_reg;

    logic [7:0]  byte_val;
    logic        byte_take;
    logic [31:0] crc_next;
    logic        suppress;

    assign byte_val  = {axiid, sh_reg[7:2]};
    // The start cycle always carries dibit 0 of byte 0, whatever the
    // counter still holds from the previous frame.
    assign byte_take = axiiv && !frame_start && (dibit_ctr_reg == 2'd3);
    assign crc_next  = crc_step(frame_start ? CRC_INIT : crc_reg, axiid);

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_reg        <= 8'h00;
            dibit_ctr_reg <= 2'd0;
            byte_ctr_reg  <= 11'd0;
            crc_reg       <= 32'h0;
            ovf_reg       <= 1'b0;
        end else if (frame_start) begin
            sh_reg        <= {axiid, 6'b0};
            dibit_ctr_reg <= 2'd1;
            byte_ctr_reg  <= 11'd0;
            crc_reg       <= crc_next;
            ovf_reg       <= 1'b0;
        end else if (axiiv) begin
            sh_reg        <= byte_val;
            dibit_ctr_reg <= dibit_ctr_reg + 2'd1;
            crc_reg       <= crc_next;
            if (byte_take) begin
                if (byte_ctr_reg == MAX_LEN) begin
                    ovf_reg <= 1'b1;
                end else begin
                    byte_ctr_reg <= byte_ctr_reg + 11'd1;
                end
            end
        end
    end

    // Byte output: one cycle after the fourth dibit.
    logic       axiov_reg;
    logic [7:0] axiod_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            axiov_reg <= 1'b0;
            axiod_reg <= 8'h00;
        end else begin
            axiov_reg <= byte_take && !suppress;
            if (byte_take && !suppress) begin
                axiod_reg <= byte_val;
            end
        end
    end

    assign axiov = axiov_reg;
    assign axiod = axiod_reg;

    // ------------------------------------------------------------------
    // Destination address filter
    // ------------------------------------------------------------------
`ifdef ETH_MAC_FILTER_EN
    logic [7:0] mac_bytes [8];
    logic [2:0] da_idx;
    logic       in_da;
    logic       mac_eq;
    logic       bc_eq;
    logic       mac_hit_reg;
    logic       bc_hit_reg;
    logic       addr_dec_reg;
    logic       addr_pass_reg;

    // Wire-order table of the station address; entries 6..7 pad the
    // table so the 3-bit index never falls outside it.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_mac_byte
            if (gi < 6) begin : g_addr
                assign mac_bytes[gi] = MY_MAC[47 - 8*gi -: 8];
            end else begin : g_pad
                assign mac_bytes[gi] = 8'h00;
            end
        end
    endgenerate

    assign da_idx = byte_ctr_reg[2:0];
    assign in_da  = (byte_ctr_reg < 11'd6);
    assign mac_eq = (byte_val == mac_bytes[da_idx]);
    assign bc_eq  = (byte_val == 8'hFF);

    always_ff @(posedge clk) begin
        if (rst) begin
            mac_hit_reg   <= 1'b0;
            bc_hit_reg    <= 1'b0;
            addr_dec_reg  <= 1'b0;
            addr_pass_reg <= 1'b0;
        end else if (frame_start) begin
            mac_hit_reg   <= 1'b1;
            bc_hit_reg    <= 1'b1;
            addr_dec_reg  <= 1'b0;
            addr_pass_reg <= 1'b0;
        end else if (byte_take && in_da) begin
            mac_hit_reg <= mac_hit_reg && mac_eq;
            bc_hit_reg  <= bc_hit_reg && bc_eq;
            if (da_idx == 3'd5) begin
                addr_dec_reg  <= 1'b1;
                addr_pass_reg <= (mac_hit_reg && mac_eq) || (bc_hit_reg && bc_eq);
            end
        end
    end

    // Decision is made as byte 5 is taken, so byte 5 itself still goes out.
    assign suppress = addr_dec_reg && !addr_pass_reg;

    logic addr_res_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_res_reg <= 1'b1;
        end else if (frame_start) begin
            addr_res_reg <= 1'b1;
        end else if (frame_end) begin
            // Undecided (fewer than 6 bytes) reads as a miss.
            addr_res_reg <= addr_pass_reg;
        end
    end

    assign addr_ok = addr_res_reg;
`else
    assign suppress = 1'b0;
    assign addr_ok  = 1'b1;
`endif

    // ------------------------------------------------------------------
    // End-of-frame status: captured as axiiv falls, shown with done,
    // held until the next frame starts.
    // ------------------------------------------------------------------
    logic        done_reg;
    logic        fcs_ok_reg;
    logic        runt_reg;
    logic        oversize_reg;
    logic [10:0] len_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            done_reg     <= 1'b0;
            fcs_ok_reg   <= 1'b0;
            runt_reg     <= 1'b0;
            oversize_reg <= 1'b0;
            len_reg      <= 11'd0;
        end else begin
            done_reg <= frame_end;
            if (frame_start) begin
                fcs_ok_reg   <= 1'b0;
                runt_reg     <= 1'b0;
                oversize_reg <= 1'b0;
                len_reg      <= 11'd0;
            end else if (frame_end) begin
                fcs_ok_reg   <= (crc_reg == CRC_RESIDUE) && (dibit_ctr_reg == 2'd0) && !ovf_reg;
                runt_reg     <= (byte_ctr_reg < MIN_LEN);
                oversize_reg <= ovf_reg;
                len_reg      <= byte_ctr_reg;
            end
        end
    end

    assign done     = done_reg;
    assign fcs_ok   = fcs_ok_reg;
    assign runt     = runt_reg;
    assign oversize = oversize_reg;
    assign len      = len_reg;

endmodule

// File: tb/tb_eth_byte_fcs.sv
// ============================================================================
// tb_eth_byte_fcs
// Drives two instances of eth_byte_fcs with the same dibit stream:
//   A: default limits, MY_MAC matching the 00:01:02:03:04:05 test frames
//   B: MAX_BYTES=16, MY_MAC=02:00:00:00:00:01
// Expected bytes and per-frame status are queued when a frame is driven and
// popped by per-instance monitors sampling on the falling clock edge.
// ============================================================================
module tb_eth_byte_fcs;

    localparam logic [47:0] MAC_A = 48'h00_01_02_03_04_05;
    localparam logic [47:0] MAC_B = 48'h02_00_00_00_00_01;
    localparam int          MAX_A = 1522;
    localparam int          MAX_B = 16;
    localparam int          MIN_B = 64;
`ifdef ETH_MAC_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    typedef struct packed {
        logic        fcs_ok;
        logic        runt;
        logic        oversize;
        logic        addr_ok;
        logic [10:0] len;
        logic        with_next;
    } status_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        axiiv;
    logic [1:0]  axiid;

    logic        a_axiov, a_done, a_fcs_ok, a_runt, a_oversize, a_addr_ok;
    logic [7:0]  a_axiod;
    logic [10:0] a_len;
    logic        b_axiov, b_done, b_fcs_ok, b_runt, b_oversize, b_addr_ok;
    logic [7:0]  b_axiod;
    logic [10:0] b_len;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] frm [$];
    logic [7:0] byte_q_a [$];
    logic [7:0] byte_q_b [$];
    status_t    st_q_a [$];
    status_t    st_q_b [$];

    always #10 clk = ~clk;

    eth_byte_fcs #(.MIN_BYTES(MIN_B), .MAX_BYTES(MAX_A), .MY_MAC(MAC_A)) u_a (
        .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
        .axiov(a_axiov), .axiod(a_axiod), .done(a_done), .fcs_ok(a_fcs_ok),
        .runt(a_runt), .oversize(a_oversize), .addr_ok(a_addr_ok), .len(a_len)
    );

    eth_byte_fcs #(.MIN_BYTES(MIN_B), .MAX_BYTES(MAX_B), .MY_MAC(MAC_B)) u_b (
        .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
        .axiov(b_axiov), .axiod(b_axiod), .done(b_done), .fcs_ok(b_fcs_ok),
        .runt(b_runt), .oversize(b_oversize), .addr_ok(b_addr_ok), .len(b_len)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] crc32_bytes();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < frm.size(); i++) begin
            c = c ^ {24'h0, frm[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    function automatic bit da_match(input logic [47:0] mac);
        logic [47:0] da;
        if (frm.size() < 6) return 1'b0;
        da = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
        return (da == mac) || (da == 48'hFFFF_FFFF_FFFF);
    endfunction

    function automatic bit keep_byte(input logic [47:0] mac, input int idx);
        if (!FILTER || idx < 6) return 1'b1;
        return da_match(mac);
    endfunction

    function automatic status_t model_status(input logic [47:0] mac, input int max_b,
                                             input int extra, input bit good, input bit gap1);
        status_t s;
        int n;
        n           = frm.size();
        s.oversize  = (n > max_b);
        s.len       = 11'((n > max_b) ? max_b : n);
        s.runt      = (int'(s.len) < MIN_B);
        s.fcs_ok    = good && (extra == 0) && !s.oversize;
        s.addr_ok   = FILTER ? da_match(mac) : 1'b1;
        s.with_next = gap1;
        return s;
    endfunction

    task automatic push_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            if (keep_byte(MAC_A, i)) byte_q_a.push_back(frm[i]);
            if (keep_byte(MAC_B, i)) byte_q_b.push_back(frm[i]);
        end
    endtask

    task automatic push_status(input int extra, input bit good, input bit gap1);
        st_q_a.push_back(model_status(MAC_A, MAX_A, extra, good, gap1));
        st_q_b.push_back(model_status(MAC_B, MAX_B, extra, good, gap1));
    endtask

    // ---------------- frame builders ----------------
    task automatic load_frame1();
        logic [7:0] s [13];
        s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'h26, 8'h39, 8'hF4, 8'hCB};
        frm.delete();
        for (int i = 0; i < 13; i++) frm.push_back(s[i]);
    endtask

    task automatic append_fcs();
        logic [31:0] c;
        c = crc32_bytes();
        frm.push_back(c[7:0]);
        frm.push_back(c[15:8]);
        frm.push_back(c[23:16]);
        frm.push_back(c[31:24]);
    endtask

    task automatic load_frame2();
        frm.delete();
        for (int i = 0; i < 60; i++) frm.push_back(8'(i));
        append_fcs();
    endtask

    task automatic load_da_frame(input logic [47:0] da, input int payload);
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(da[47 - 8*i -: 8]);
        for (int i = 0; i < payload; i++) frm.push_back(8'(8'hA0 + i));
        append_fcs();
    endtask

    // ---------------- drivers ----------------
    task automatic drive_dibit(input logic [1:0] d);
        @(posedge clk);
        #1;
        axiiv = 1'b1;
        axiid = d;
    endtask

    task automatic drive_bytes(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = frm[i];
            for (int k = 0; k < 4; k++) drive_dibit(b[2*k +: 2]);
        end
    endtask

    task automatic idle(input int n);
        for (int g = 0; g < n; g++) begin
            @(posedge clk);
            #1;
            axiiv = 1'b0;
            axiid = 2'b00;
        end
    endtask

    task automatic send_frame(input int extra, input logic [1:0] extra_dib, input int gap);
        drive_bytes(frm.size());
        for (int e = 0; e < extra; e++) drive_dibit(extra_dib);
        idle(gap);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (a_axiov) begin
            check("a_byte_pending", 32'(byte_q_a.size() != 0), 32'd1);
            if (byte_q_a.size() != 0) begin
                logic [7:0] e;
                e = byte_q_a.pop_front();
                $display("a byte %02h (exp %02h)", a_axiod, e);
                check("a_byte", 32'(a_axiod), 32'(e));
            end
        end
        if (a_done) begin
            check("a_done_pending", 32'(st_q_a.size() != 0), 32'd1);
            if (st_q_a.size() != 0) begin
                status_t s;
                s = st_q_a.pop_front();
                $display("a done fcs_ok=%0b runt=%0b oversize=%0b addr_ok=%0b len=%0d",
                         a_fcs_ok, a_runt, a_oversize, a_addr_ok, a_len);
                check("a_fcs_ok",   32'(a_fcs_ok),   32'(s.fcs_ok));
                check("a_runt",     32'(a_runt),     32'(s.runt));
                check("a_oversize", 32'(a_oversize), 32'(s.oversize));
                check("a_addr_ok",  32'(a_addr_ok),  32'(s.addr_ok));
                check("a_len",      32'(a_len),      32'(s.len));
                check("a_done_vs_next_frame", 32'(axiiv), 32'(s.with_next));
            end
        end
    end

    always @(negedge clk) begin
        if (b_axiov) begin
            check("b_byte_pending", 32'(byte_q_b.size() != 0), 32'd1);
            if (byte_q_b.size() != 0) begin
                logic [7:0] e;
                e = byte_q_b.pop_front();
                $display("b byte %02h (exp %02h)", b_axiod, e);
                check("b_byte", 32'(b_axiod), 32'(e));
            end
        end
        if (b_done) begin
            check("b_done_pending", 32'(st_q_b.size() != 0), 32'd1);
            if (st_q_b.size() != 0) begin
                status_t s;
                s = st_q_b.pop_front();
                $display("b done fcs_ok=%0b runt=%0b oversize=%0b addr_ok=%0b len=%0d",
                         b_fcs_ok, b_runt, b_oversize, b_addr_ok, b_len);
                check("b_fcs_ok",   32'(b_fcs_ok),   32'(s.fcs_ok));
                check("b_runt",     32'(b_runt),     32'(s.runt));
                check("b_oversize", 32'(b_oversize), 32'(s.oversize));
                check("b_addr_ok",  32'(b_addr_ok),  32'(s.addr_ok));
                check("b_len",      32'(b_len),      32'(s.len));
                check("b_done_vs_next_frame", 32'(axiiv), 32'(s.with_next));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst   = 1'b1;
        axiiv = 1'b0;
        axiid = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_axiov",    32'({a_axiov, b_axiov}),       32'd0);
        check("rst_axiod",    32'({a_axiod, b_axiod}),       32'd0);
        check("rst_done",     32'({a_done, b_done}),         32'd0);
        check("rst_fcs_ok",   32'({a_fcs_ok, b_fcs_ok}),     32'd0);
        check("rst_runt",     32'({a_runt, b_runt}),         32'd0);
        check("rst_oversize", 32'({a_oversize, b_oversize}), 32'd0);
        check("rst_addr_ok",  32'({a_addr_ok, b_addr_ok}),   32'd3);
        check("rst_len",      32'({a_len, b_len}),           32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);

        // "123456789" + FCS
        load_frame1();
        push_bytes(13);
        push_status(0, 1'b1, 1'b0);
        send_frame(0, 2'b00, 6);

        // 64-byte good frame, then the same with one bit flipped
        load_frame2();
        push_bytes(64);
        push_status(0, 1'b1, 1'b0);
        send_frame(0, 2'b00, 6);
        frm[10] = frm[10] ^ 8'h01;
        push_bytes(64);
        push_status(0, 1'b0, 1'b0);
        send_frame(0, 2'b00, 6);

        // Trailing partial byte
        load_frame1();
        push_bytes(13);
        push_status(1, 1'b1, 1'b0);
        send_frame(1, 2'b10, 6);

        // Back-to-back with a one-cycle gap
        load_frame2();
        push_bytes(64);
        push_status(0, 1'b1, 1'b1);
        send_frame(0, 2'b00, 1);
        push_bytes(64);
        push_status(0, 1'b1, 1'b0);
        send_frame(0, 2'b00, 6);

        // Single-dibit frame
        frm.delete();
        push_status(1, 1'b0, 1'b0);
        send_frame(1, 2'b11, 6);

        // Reset after 20 bytes: no done for it, then a clean frame
        load_frame2();
        push_bytes(20);
        drive_bytes(20);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        axiiv = 1'b0;
        idle(4);
        check("abort_bytes_drained_a", 32'(byte_q_a.size()), 32'd0);
        check("abort_bytes_drained_b", 32'(byte_q_b.size()), 32'd0);
        push_bytes(64);
        push_status(0, 1'b1, 1'b0);
        send_frame(0, 2'b00, 6);

        // Address-filter frames: unicast miss for B, broadcast hit
        load_da_frame(48'h02_00_00_00_00_02, 54);
        push_bytes(frm.size());
        push_status(0, 1'b1, 1'b0);
        send_frame(0, 2'b00, 6);
        load_da_frame(48'hFF_FF_FF_FF_FF_FF, 10);
        push_bytes(frm.size());
        push_status(0, 1'b1, 1'b0);
        send_frame(0, 2'b00, 6);
        load_da_frame(MAC_B, 4);
        push_bytes(frm.size());
        push_status(0, 1'b1, 1'b0);
        send_frame(0, 2'b00, 6);

        // Let everything drain, bounded
        for (int i = 0; i < 300; i++) begin
            if (byte_q_a.size() + byte_q_b.size() + st_q_a.size() + st_q_b.size() == 0) break;
            @(posedge clk);
        end
        check("drain_bytes",  32'(byte_q_a.size() + byte_q_b.size()), 32'd0);
        check("drain_status", 32'(st_q_a.size() + st_q_b.size()),    32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
